audio_player: RTL and testbench

AUDIO_PLAYER -- requirements
Module: audio_player

---
 rtl/audio_pkg.sv | 16 +
 rtl/audio_pwm_dac.sv | 19 +
 rtl/audio_player.sv | 144 ++++++++++++++
 tb/tb_audio_player.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio player block.
package audio_pkg;
    localparam int ADDR_W   = 19;
    localparam int SAMPLE_W = 8;
    localparam int DIV_W    = 16;

    localparam logic [ADDR_W-1:0] DEF_BASE_ADDR  = 19'd3;
    localparam int                DEF_SAMPLE_DIV = 3125;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PLAY  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;
endpackage

// File: rtl/audio_pwm_dac.sv
// 8-bit free-running PWM DAC: output high while counter is below the sample value.
module audio_pwm_dac
    import audio_pkg::*;
(
    input  logic                clk,
    input  logic                clr,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                enable,
    output logic                pwm
);
    logic [SAMPLE_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) cnt_q <= '0;
        else     cnt_q <= cnt_q + 1'b1;
    end

    assign pwm = enable && (cnt_q < sample);
endmodule

// File: rtl/audio_player.sv
// Sample playback sequencer: fetches bytes from memory and plays them through the PWM DAC.
// Define AUDIO_PREFETCH_EN for the gapless build that fetches the next sample during PLAY.
//   state | meaning
//   IDLE  | waiting for start
//   FETCH | memory request outstanding for audio_addr
//   PLAY  | cur_sample driven for SAMPLE_DIV clocks
//   DONE  | playback finished, audio_done follows
module audio_player
    import audio_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int                SAMPLE_DIV = DEF_SAMPLE_DIV
)(
    input  logic                clk,
    input  logic                clr,
    input  logic                start,
    input  logic [ADDR_W-1:0]   stop_pos,
    input  logic [SAMPLE_W-1:0] mem_data,
    input  logic                data_ready,
    output logic                audio_req,
    output logic [ADDR_W-1:0]   audio_addr,
    output logic                audio_done,
    output logic                busy,
    output logic                audio_pwm,
    output logic                shutdown_n
);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q, end_q, addr_inc_d;
    logic [SAMPLE_W-1:0] cur_sample_q;
    logic [DIV_W-1:0]    div_cnt_q;
    logic                req_q, done_q, busy_q, shdn_q, period_end_d;
`ifdef AUDIO_PREFETCH_EN
    logic [SAMPLE_W-1:0] next_sample_q;
    logic                next_valid_q;
`endif

    assign addr_inc_d   = addr_q + 1'b1;
    assign period_end_d = (div_cnt_q == DIV_LAST);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            end_q         <= '0;
            cur_sample_q  <= '0;
            div_cnt_q     <= '0;
            req_q         <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            shdn_q        <= 1'b0;
`ifdef AUDIO_PREFETCH_EN
            next_sample_q <= '0;
            next_valid_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= start;
                    if (start) begin
                        end_q     <= stop_pos;
                        addr_q    <= BASE_ADDR;
                        div_cnt_q <= '0;
                        if (stop_pos <= BASE_ADDR) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_FETCH;
                            req_q   <= 1'b1;
                            shdn_q  <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (data_ready) begin
                        cur_sample_q <= mem_data;
                        div_cnt_q    <= '0;
                        req_q        <= 1'b0;
                        state_q      <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (period_end_d) begin
                        div_cnt_q <= '0;
                        addr_q    <= addr_inc_d;
                        if (addr_inc_d == end_q) begin
                            state_q <= ST_DONE;
                            req_q   <= 1'b0;
                            shdn_q  <= 1'b0;
`ifdef AUDIO_PREFETCH_EN
                        end else if (req_q && data_ready) begin
                            // late prefetch landing on the boundary goes straight to the DAC
                            cur_sample_q <= mem_data;
                            req_q        <= 1'b0;
                        end else if (next_valid_q) begin
                            cur_sample_q <= next_sample_q;
                            next_valid_q <= 1'b0;
`endif
                        end else begin
                            state_q <= ST_FETCH;
                            req_q   <= 1'b1;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
`ifdef AUDIO_PREFETCH_EN
                        if (req_q && data_ready) begin
                            next_sample_q <= mem_data;
                            next_valid_q  <= 1'b1;
                            req_q         <= 1'b0;
                        end else if (!req_q && !next_valid_q && addr_inc_d != end_q) begin
                            req_q <= 1'b1;
                        end
`endif
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef AUDIO_PREFETCH_EN
    // during PLAY the outstanding request is always for the following sample
    assign audio_addr = (state_q == ST_PLAY) ? addr_inc_d : addr_q;
`else
    assign audio_addr = addr_q;
`endif
    assign audio_req  = req_q;
    assign audio_done = done_q;
    assign busy       = busy_q;
    assign shutdown_n = shdn_q;

    audio_pwm_dac u_dac (
        .clk    (clk),
        .clr    (clr),
        .sample (cur_sample_q),
        .enable (state_q == ST_PLAY),
        .pwm    (audio_pwm)
    );
endmodule

// File: tb/tb_audio_player.sv
// Self-checking bench for audio_player with a latency-programmable memory responder.
module tb_audio_player;
    localparam int DIV  = 300;
    localparam int BASE = 3;

    logic        clk = 1'b0;
    logic        clr, start, data_ready;
    logic [18:0] stop_pos;
    logic [7:0]  mem_data;
    logic        audio_req, audio_done, busy, audio_pwm, shutdown_n;
    logic [18:0] audio_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    audio_player #(.BASE_ADDR(19'd3), .SAMPLE_DIV(DIV)) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .stop_pos   (stop_pos),
        .mem_data   (mem_data),
        .data_ready (data_ready),
        .audio_req  (audio_req),
        .audio_addr (audio_addr),
        .audio_done (audio_done),
        .busy       (busy),
        .audio_pwm  (audio_pwm),
        .shutdown_n (shutdown_n)
    );

    // event log indexed by negedge count
    int   ncyc = 0;
    int   rdy_log[$], rise_log[$], done_log[$], rd_log[$];
    logic req_prev = 1'b0;

    always @(negedge clk) begin
        ncyc++;
        if (data_ready) rdy_log.push_back(ncyc);
        if (audio_req && !req_prev) rise_log.push_back(ncyc);
        req_prev = audio_req;
        if (audio_done) done_log.push_back(ncyc);
        total++;
        if (!shutdown_n && audio_pwm !== 1'b0) begin
            bad++;
            $display("FAIL pwm_when_off: audio_pwm=%b want 0 at cycle %0d", audio_pwm, ncyc);
        end
`ifndef AUDIO_PREFETCH_EN
        total++;
        if (audio_req && audio_pwm !== 1'b0) begin
            bad++;
            $display("FAIL pwm_in_fetch: audio_pwm=%b want 0 at cycle %0d", audio_pwm, ncyc);
        end
`endif
    end

    // memory: captures a request, holds it for lat cycles, then strobes data_ready once
    logic [7:0]  mem [0:63];
    int          lat = 2;
    logic [18:0] a_cap;
    int          k_wait;

    initial begin
        data_ready = 1'b0;
        mem_data   = 8'd0;
        forever begin
            @(posedge clk); #1;
            data_ready = 1'b0;
            if (audio_req === 1'b1 && !clr) begin
                a_cap = audio_addr;
                rd_log.push_back(int'(a_cap));
                k_wait = 1;
                while (k_wait < lat) begin
                    @(posedge clk); #1;
                    if (clr) break;
                    total++;
                    if (audio_req !== 1'b1 || audio_addr !== a_cap) begin
                        bad++;
                        $display("FAIL req_hold: req=%b addr=%0d want req=1 addr=%0d", audio_req, audio_addr, a_cap);
                    end
                    k_wait++;
                end
                if (!clr) begin
                    mem_data   = mem[a_cap[5:0]];
                    data_ready = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic clear_logs();
        rdy_log.delete(); rise_log.delete(); done_log.delete(); rd_log.delete();
    endtask

    task automatic do_start(input int sp, output int s);
        @(posedge clk); #1;
        start    = 1'b1;
        stop_pos = 19'(sp);
        s        = ncyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string tag);
        int n = 0;
        while (audio_done !== 1'b1 && n < limit) begin tick(); n++; end
        total++;
        if (audio_done !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout: audio_done=%b want 1 within %0d cycles", tag, audio_done, limit);
        end
    endtask

    task automatic test_reset();
        clr = 1'b1; start = 1'b0; stop_pos = '0;
        repeat (3) tick();
        total += 6;
        if (audio_req  !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", audio_req); end
        if (audio_addr !== '0)   begin bad++; $display("FAIL rst_addr: got %0d want 0", audio_addr); end
        if (audio_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", audio_done); end
        if (busy       !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (audio_pwm  !== 1'b0) begin bad++; $display("FAIL rst_pwm: got %b want 0", audio_pwm); end
        if (shutdown_n !== 1'b0) begin bad++; $display("FAIL rst_shdn: got %b want 0", shutdown_n); end
        clr = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_playback();
        int s, sp, n, exp_done;
        for (int run = 0; run < 5; run++) begin
            if (run == 0) begin sp = 6; lat = 2; end
            else begin sp = BASE + $urandom_range(1, 4); lat = $urandom_range(1, 8); end
            for (int a = 0; a < 64; a++) mem[a] = 8'($urandom);
            n = sp - BASE;
            clear_logs();
            do_start(sp, s);
            wait_done(n * (DIV + 20) + 50, "play");
            total++;
            if (busy !== 1'b1) begin bad++; $display("FAIL play_busy_at_done: got %b want 1", busy); end
            tick();
            total += 2;
            if (busy !== 1'b0) begin bad++; $display("FAIL play_busy_after: got %b want 0", busy); end
            if (audio_done !== 1'b0) begin bad++; $display("FAIL play_done_width: got %b want 0", audio_done); end
            total++;
            if (rd_log.size() != n || rdy_log.size() != n) begin
                bad++;
                $display("FAIL play_reads: reads=%0d readies=%0d want %0d", rd_log.size(), rdy_log.size(), n);
            end else begin
                for (int k = 0; k < n; k++) begin
                    total++;
                    if (rd_log[k] != BASE + k) begin
                        bad++; $display("FAIL play_addr[%0d]: got %0d want %0d", k, rd_log[k], BASE + k);
                    end
                end
                total++;
                if (done_log.size() != 1) begin
                    bad++; $display("FAIL play_done_count: got %0d want 1", done_log.size());
                end else begin
`ifdef AUDIO_PREFETCH_EN
                    exp_done = rdy_log[0] + n * DIV + 2;
`else
                    exp_done = rdy_log[n-1] + DIV + 2;
`endif
                    total++;
                    if (done_log[0] != exp_done) begin
                        bad++; $display("FAIL play_done_time: got %0d want %0d", done_log[0], exp_done);
                    end
                end
`ifndef AUDIO_PREFETCH_EN
                total++;
                if (rise_log.size() != n) begin
                    bad++; $display("FAIL play_req_count: got %0d want %0d", rise_log.size(), n);
                end else begin
                    for (int k = 0; k < n; k++) begin
                        exp_done = (k == 0) ? s + 1 : rdy_log[k-1] + DIV + 1;
                        total++;
                        if (rise_log[k] != exp_done) begin
                            bad++; $display("FAIL play_req_time[%0d]: got %0d want %0d", k, rise_log[k], exp_done);
                        end
                    end
                end
`endif
            end
            repeat (3) tick();
        end
    endtask

    task automatic test_zero_length();
        int s, sp;
        for (int run = 0; run < 2; run++) begin
            sp = (run == 0) ? BASE : $urandom_range(0, BASE - 1);
            clear_logs();
            do_start(sp, s);
            wait_done(10, "zero");
            tick();
            total += 3;
            if (rise_log.size() != 0) begin bad++; $display("FAIL zero_req: got %0d requests want 0", rise_log.size()); end
            if (done_log.size() != 1) begin
                bad++; $display("FAIL zero_done_count: got %0d want 1", done_log.size());
            end else if (done_log[0] != s + 2) begin
                bad++; $display("FAIL zero_done_time: got %0d want %0d", done_log[0], s + 2);
            end
            if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy: got %b want 0", busy); end
        end
    endtask

    task automatic test_pwm();
        int s, n0, st, highs, g;
        mem[3] = 8'd64; mem[4] = 8'd255; mem[5] = 8'd0;
        lat = 1;
        clear_logs();
        do_start(6, s);
        g = 0;
        while (rdy_log.size() < 1 && g < 100) begin tick(); g++; end
        total++;
        if (rdy_log.size() < 1) begin bad++; $display("FAIL pwm_first_ready: got none want 1"); return; end
        n0 = rdy_log[0];
        while (ncyc < n0 + 1) tick();
        highs = 0;
        for (int i = 0; i < 256; i++) begin tick(); if (audio_pwm) highs++; end
        total++;
        if (highs != 64) begin bad++; $display("FAIL pwm_64: got %0d high want 64", highs); end
`ifdef AUDIO_PREFETCH_EN
        st = n0 + DIV + 1;
`else
        g = 0;
        while (rdy_log.size() < 2 && g < 500) begin tick(); g++; end
        total++;
        if (rdy_log.size() < 2) begin bad++; $display("FAIL pwm_second_ready: got none want 1"); return; end
        st = rdy_log[1] + 1;
`endif
        while (ncyc < st) tick();
        highs = 0;
        for (int i = 0; i < 256; i++) begin tick(); if (audio_pwm) highs++; end
        total++;
        if (highs != 255) begin bad++; $display("FAIL pwm_255: got %0d high want 255", highs); end
        while (ncyc < st + DIV - 1) tick();
        highs = 0;
        g = 0;
        while (audio_done !== 1'b1 && g < 800) begin tick(); g++; if (audio_pwm) highs++; end
        total += 2;
        if (audio_done !== 1'b1) begin bad++; $display("FAIL pwm_done: got %b want 1", audio_done); end
        if (highs != 0) begin bad++; $display("FAIL pwm_0: got %0d high want 0", highs); end
        repeat (3) tick();
    endtask

    task automatic test_ignore_start();
        int s, dummy, g;
        lat = 3;
        for (int a = 0; a < 64; a++) mem[a] = 8'($urandom);
        clear_logs();
        do_start(6, s);
        g = 0;
        while (rdy_log.size() < 1 && g < 100) begin tick(); g++; end
        repeat (40) tick();
        do_start(20, dummy);
        repeat (300) tick();
        do_start(4, dummy);
        wait_done(3 * (DIV + 20), "ign");
        repeat (5) tick();
        total += 3;
        if (rd_log.size() != 3 || rd_log[0] != 3 || rd_log[1] != 4 || rd_log[2] != 5) begin
            bad++; $display("FAIL ign_reads: got %0d reads want addrs 3,4,5", rd_log.size());
        end
        if (done_log.size() != 1) begin bad++; $display("FAIL ign_done_count: got %0d want 1", done_log.size()); end
        if (busy !== 1'b0 || audio_req !== 1'b0) begin
            bad++; $display("FAIL ign_idle: busy=%b req=%b want 0 0", busy, audio_req);
        end
    endtask

    task automatic test_reset_mid_play();
        int s, g, tgt;
        lat = 2;
        clear_logs();
        do_start(10, s);
        g = 0;
        while (rdy_log.size() < 3 && g < 2000) begin tick(); g++; end
        total++;
        if (rdy_log.size() < 3) begin bad++; $display("FAIL midrst_reach: readies=%0d want 3", rdy_log.size()); return; end
`ifdef AUDIO_PREFETCH_EN
        tgt = rdy_log[2] + DIV;
`else
        tgt = rdy_log[2] + 10;
`endif
        while (ncyc < tgt) tick();
        clr = 1'b1;
        tick();
        total += 6;
        if (audio_req  !== 1'b0) begin bad++; $display("FAIL midrst_req: got %b want 0", audio_req); end
        if (audio_addr !== '0)   begin bad++; $display("FAIL midrst_addr: got %0d want 0", audio_addr); end
        if (audio_done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b want 0", audio_done); end
        if (busy       !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        if (audio_pwm  !== 1'b0) begin bad++; $display("FAIL midrst_pwm: got %b want 0", audio_pwm); end
        if (shutdown_n !== 1'b0) begin bad++; $display("FAIL midrst_shdn: got %b want 0", shutdown_n); end
        clr = 1'b0;
        done_log.delete();
        repeat (40) tick();
        total += 2;
        if (done_log.size() != 0) begin bad++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_log.size()); end
        if (audio_req !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL midrst_stays_idle: req=%b busy=%b want 0 0", audio_req, busy);
        end
    endtask

`ifdef AUDIO_PREFETCH_EN
    task automatic test_prefetch();
        int s, n;
        for (int run = 0; run < 2; run++) begin
            lat = (run == 0) ? 10 : 400;
            n   = (run == 0) ? 4 : 3;
            clear_logs();
            do_start(BASE + n, s);
            wait_done(n * (DIV + lat + 20) + 50, "pf");
            repeat (2) tick();
            total += 3;
            if (rd_log.size() != n) begin bad++; $display("FAIL pf_reads: got %0d want %0d", rd_log.size(), n); end
            if (done_log.size() != 1 || rdy_log.size() < 1) begin
                bad++; $display("FAIL pf_done_count: got %0d want 1", done_log.size());
            end else if (run == 0 && done_log[0] != rdy_log[0] + n * DIV + 2) begin
                bad++; $display("FAIL pf_gapless: done at %0d want %0d", done_log[0], rdy_log[0] + n * DIV + 2);
            end else if (run == 1 && done_log[0] <= rdy_log[0] + n * DIV + 2) begin
                bad++; $display("FAIL pf_underrun: done at %0d want later than %0d", done_log[0], rdy_log[0] + n * DIV + 2);
            end
            if (busy !== 1'b0) begin bad++; $display("FAIL pf_busy: got %b want 0", busy); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_length();
        test_playback();
        test_pwm();
        test_ignore_start();
        test_reset_mid_play();
`ifdef AUDIO_PREFETCH_EN
        test_prefetch();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
